// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Purpose : Load/store operation encoding shared by the execute stage, the
//           memory stage and anything else that has to decode lsuop.
// Contents: lsuop_t enum, which lists the byte/half/word loads (signed and
//           unsigned) and the byte/half/word stores.
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        LB,
        LH,
        LW,
        LBU,
        LHU,
        SB,
        SH,
        SW
    } lsuop_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Purpose : Types that cross the boundaries of the memory-access stage.
// Contents: mem_stage_in_t  - EX -> MEM pipeline payload
//           mem_stage_out_t - MEM -> WB payload
//           mem_fwd_t       - EX/MEM register view for the forwarding unit
//           lsu_state_t     - LSU bus FSM states
//           is_store()      - helper that tells stores apart from loads
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    import lsu_pkg::*;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;
    localparam int WB_SEL_W  = 2;

    typedef struct packed {
        logic [XLEN-1:0]      opr_res;
        logic [XLEN-1:0]      opr_b;
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      pc4;
        logic                 rf_en;
        logic                 dm_en;
        logic [WB_SEL_W-1:0]  wb_sel;
        lsuop_t               lsuop;
    } mem_stage_in_t;

    typedef struct packed {
        logic [XLEN-1:0]      opr_res;
        logic [XLEN-1:0]      lsu_rdata;
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      pc4;
        logic                 rf_en;
        logic [WB_SEL_W-1:0]  wb_sel;
    } mem_stage_out_t;

    typedef struct packed {
        logic                 rf_en;
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      opr_res;
    } mem_fwd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_t;

    function automatic logic is_store(input lsuop_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Purpose : req/gnt/rvalid data-bus bundle between the memory stage (master)
//           and the data memory or bus fabric (slave).
// Signals : req    - request valid, held until gnt
//           we     - 1 = store
//           addr   - word-aligned byte address
//           be     - byte enables, one per lane
//           wdata  - lane-steered store data
//           gnt    - request accepted this cycle
//           rvalid - load data valid
//           rdata  - load data
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                    req;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purpose : Purely combinational byte-lane logic for the memory stage.
//           Generates byte enables and replicated store data, pulls the
//           addressed byte or halfword out of the bus read data and extends
//           it, and flags accesses that are not naturally aligned.
// Ports   : op         in  operation being performed
//           byte_off   in  low two address bits
//           store_data in  unsteered store operand
//           load_data  in  raw bus read data
//           be         out byte enables
//           wdata      out store data replicated across every lane
//           load_ext   out selected lane, sign/zero extended
//           misaligned out half on an odd address, or word not on a 4-byte boundary
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
    import mem_stage_pkg::*;
(
    input  lsuop_t          op,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_ext,
    output logic            misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // A halfword only ever lives in the lower or upper half, so only
    // byte_off[1] is needed to pick it.
    assign byte_lane = load_data[{byte_off, 3'b000} +: 8];
    assign half_lane = byte_off[1] ? load_data[31:16] : load_data[15:0];

    // Stores replicate the operand over all lanes so that whichever lane the
    // byte enables select already holds the right bytes.
    always_comb begin
        be         = 4'b0000;
        wdata      = '0;
        load_ext   = '0;
        misaligned = 1'b0;
        case (op)
            LB: begin
                be       = 4'b0001 << byte_off;
                load_ext = {{24{byte_lane[7]}}, byte_lane};
            end
            LBU: begin
                be       = 4'b0001 << byte_off;
                load_ext = {24'b0, byte_lane};
            end
            LH: begin
                be         = 4'b0011 << {byte_off[1], 1'b0};
                load_ext   = {{16{half_lane[15]}}, half_lane};
                misaligned = byte_off[0];
            end
            LHU: begin
                be         = 4'b0011 << {byte_off[1], 1'b0};
                load_ext   = {16'b0, half_lane};
                misaligned = byte_off[0];
            end
            LW: begin
                be         = 4'b1111;
                load_ext   = load_data;
                misaligned = |byte_off;
            end
            SB: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            SH: begin
                be         = 4'b0011 << {byte_off[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                misaligned = byte_off[0];
            end
            SW: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = |byte_off;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Purpose : Memory-access stage that sits directly after execute. Holds the
//           EX/MEM pipeline register, runs the LSU bus FSM on a req/gnt/rvalid
//           data bus, stalls the front of the pipe while an access is
//           outstanding, feeds writeback and exposes the register contents to
//           the execute-stage forwarding unit.
// Ports   : clk           in  clock
//           rst           in  synchronous active-high reset
//           mem_stage_in  in  EX payload (opr_res, opr_b, rd, pc4, rf_en, dm_en, wb_sel, lsuop)
//           mem_stage_out out WB payload (opr_res, lsu_rdata, rd, pc4, rf_en, wb_sel)
//           mem_fwd_out   out {rf_en, rd, opr_res} straight from the EX/MEM register
//           lsu_stall     out freeze IF/ID/EX and hold the EX/MEM register
//           lsu_misalign  out one-cycle pulse: access in the register was misaligned and dropped
//           dbus          --  data bus, master side
// ---------------------------------------------------------------------------
module mem_stage
    import lsu_pkg::*;
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  mem_stage_in_t  mem_stage_in,
    output mem_stage_out_t mem_stage_out,
    output mem_fwd_t       mem_fwd_out,
    output logic           lsu_stall,
    output logic           lsu_misalign,
    mem_stage_if.master    dbus
);

    mem_stage_in_t         ex_mem_q;
    lsu_state_t            state_q;
    lsu_state_t            state_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  req;
    logic                  store_op;
    logic                  access_ok;
    logic                  access_bad;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  misaligned;

    lsu_align u_lsu_align (
        .op         (ex_mem_q.lsuop),
        .byte_off   (ex_mem_q.opr_res[1:0]),
        .store_data (ex_mem_q.opr_b),
        .load_data  (dbus.rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_ext   (load_ext),
        .misaligned (misaligned)
    );

    assign store_op   = is_store(ex_mem_q.lsuop);
    assign access_ok  = ex_mem_q.dm_en & ~misaligned;
    assign access_bad = ex_mem_q.dm_en &  misaligned;

    // EX/MEM register. Holding it on lsu_stall keeps every bus field stable
    // for the whole access without a separate copy of the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else if (!lsu_stall) begin
            ex_mem_q <= mem_stage_in;
        end
    end

    // LSU state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load data is captured only while waiting for it; an rvalid in any other
    // state (including one that arrives after a reset) never reaches rdata_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((state_q == WAIT_R) && dbus.rvalid) begin
            rdata_q <= load_ext;
        end
    end

    // Next state and handshake outputs. IDLE with an aligned access behaves
    // exactly like REQ, so a gnt already present in the first cycle is taken
    // and a store granted there costs no stall at all.
    always_comb begin
        state_d      = state_q;
        req          = 1'b0;
        lsu_stall    = 1'b0;
        lsu_misalign = 1'b0;
        case (state_q)
            IDLE, REQ: begin
                if ((state_q == REQ) || access_ok) begin
                    req       = 1'b1;
                    lsu_stall = 1'b1;
                    state_d   = REQ;
                    if (dbus.gnt) begin
                        if (store_op) begin
                            lsu_stall = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            state_d   = WAIT_R;
                        end
                    end
                end else if (access_bad) begin
                    lsu_misalign = 1'b1;
                end
            end
            WAIT_R: begin
                lsu_stall = 1'b1;
                if (dbus.rvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbus.req   = req;
    assign dbus.we    = ex_mem_q.dm_en & store_op;
    assign dbus.addr  = ADDR_WIDTH'({ex_mem_q.opr_res[XLEN-1:2], 2'b00});
    assign dbus.be    = ex_mem_q.dm_en ? lane_be : 4'b0000;
    assign dbus.wdata = lane_wdata;

    // A dropped misaligned load must not write the register file.
    assign mem_stage_out.opr_res   = ex_mem_q.opr_res;
    assign mem_stage_out.lsu_rdata = (state_q == DONE) ? rdata_q : '0;
    assign mem_stage_out.rd        = ex_mem_q.rd;
    assign mem_stage_out.pc4       = ex_mem_q.pc4;
    assign mem_stage_out.rf_en     = ex_mem_q.rf_en & ~access_bad;
    assign mem_stage_out.wb_sel    = ex_mem_q.wb_sel;

    assign mem_fwd_out.rf_en   = ex_mem_q.rf_en;
    assign mem_fwd_out.rd      = ex_mem_q.rd;
    assign mem_fwd_out.opr_res = ex_mem_q.opr_res;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Purpose : Self-checking bench for mem_stage. The bench plays the data-bus
//           slave, feeds one instruction at a time into the EX/MEM register
//           and follows it cycle by cycle until the stage lets it go.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    import lsu_pkg::*;
    import mem_stage_pkg::*;

    // One instruction with its bus timing and everything expected of it.
    typedef struct {
        lsuop_t      op;
        logic        dm_en;
        logic        rf_en;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] opr_b;
        logic [31:0] rdata;
        int          gnt_delay;
        int          rv_delay;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_misalign;
        int          exp_stall;
        logic        exp_wb_rf_en;
    } vec_t;

    localparam int NVEC = 13;
    localparam int NRND = 300;

    logic           clk;
    logic           rst;
    mem_stage_in_t  ex_in;
    mem_stage_out_t wb_out;
    mem_fwd_t       fwd_out;
    logic           lsu_stall;
    logic           lsu_misalign;
    int             errors;
    int             checks;
    vec_t           vectors [NVEC];

    mem_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dbus ();

    mem_stage #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_stage_in  (ex_in),
        .mem_stage_out (wb_out),
        .mem_fwd_out   (fwd_out),
        .lsu_stall     (lsu_stall),
        .lsu_misalign  (lsu_misalign),
        .dbus          (dbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        check_output(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // Reference behaviour written from the access rules: lane arithmetic for
    // enables/data and a simple cycle budget for the stall length.
    function automatic vec_t model_vector(input lsuop_t op, input logic dm_en, input logic rf_en,
                                          input logic [4:0] rd, input logic [31:0] addr,
                                          input logic [31:0] opr_b, input logic [31:0] rdata,
                                          input int gnt_delay, input int rv_delay);
        vec_t        v;
        int          off;
        bit          half;
        bit          word;
        bit          store;
        logic [31:0] b;
        logic [31:0] h;
        v.op        = op;
        v.dm_en     = dm_en;
        v.rf_en     = rf_en;
        v.rd        = rd;
        v.addr      = addr;
        v.opr_b     = opr_b;
        v.rdata     = rdata;
        v.gnt_delay = gnt_delay;
        v.rv_delay  = rv_delay;
        off   = int'(addr % 4);
        half  = (op == LH) || (op == LHU) || (op == SH);
        word  = (op == LW) || (op == SW);
        store = (op == SB) || (op == SH) || (op == SW);
        v.exp_misalign = dm_en && ((half && (off % 2 != 0)) || (word && off != 0));
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (word) begin
            v.exp_be    = 4'hF;
            v.exp_wdata = opr_b;
        end else if (half) begin
            v.exp_be    = 4'(3 << ((off / 2) * 2));
            v.exp_wdata = (opr_b & 32'hFFFF) * 32'h0001_0001;
        end else begin
            v.exp_be    = 4'(1 << off);
            v.exp_wdata = (opr_b & 32'hFF) * 32'h0101_0101;
        end
        v.exp_rdata = 32'h0;
        if (dm_en && !v.exp_misalign && !store) begin
            case (op)
                LB:      v.exp_rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                LH:      v.exp_rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                LBU:     v.exp_rdata = b;
                LHU:     v.exp_rdata = h;
                default: v.exp_rdata = rdata;
            endcase
        end
        if (!dm_en || v.exp_misalign) v.exp_stall = 0;
        else if (store)               v.exp_stall = gnt_delay;
        else                          v.exp_stall = gnt_delay + rv_delay + 1;
        v.exp_wb_rf_en = rf_en && !v.exp_misalign;
        return v;
    endfunction

    // Presents one instruction, acts as bus slave and checks every cycle it
    // spends in the EX/MEM register. Entered and left just before a clock
    // edge on which the register accepts new input.
    task automatic apply_stimulus(input vec_t v, input string tag, input bit noise);
        bit          mem_ok;
        bit          is_load;
        bit          done;
        bit          hit;
        bit          waiting;
        logic [31:0] pc4;
        logic [1:0]  wb_sel;
        mem_ok  = v.dm_en && !v.exp_misalign;
        is_load = !((v.op == SB) || (v.op == SH) || (v.op == SW));
        pc4     = $urandom;
        wb_sel  = 2'($urandom_range(0, 3));
        ex_in.opr_res = v.addr;
        ex_in.opr_b   = v.opr_b;
        ex_in.rd      = v.rd;
        ex_in.pc4     = pc4;
        ex_in.rf_en   = v.rf_en;
        ex_in.dm_en   = v.dm_en;
        ex_in.wb_sel  = wb_sel;
        ex_in.lsuop   = v.op;
        @(posedge clk);
        done = 1'b0;
        for (int c = 0; c <= v.exp_stall + 3 && !done; c++) begin
            @(negedge clk);
            hit     = mem_ok && is_load && (c == v.gnt_delay + v.rv_delay);
            waiting = mem_ok && is_load && (c > v.gnt_delay) && (c < v.gnt_delay + v.rv_delay);
            dbus.gnt    = mem_ok && (c == v.gnt_delay);
            dbus.rvalid = hit || (noise && !waiting && ($urandom_range(0, 3) == 0));
            dbus.rdata  = hit ? v.rdata : $urandom;
            #1;
            check_bit($sformatf("%s c%0d stall", tag, c), lsu_stall, c < v.exp_stall);
            check_bit($sformatf("%s c%0d req", tag, c), dbus.req, mem_ok && (c <= v.gnt_delay));
            check_bit($sformatf("%s c%0d misalign", tag, c), lsu_misalign, v.exp_misalign && (c == 0));
            check_bit($sformatf("%s c%0d fwd rf_en", tag, c), fwd_out.rf_en, v.rf_en);
            check_output($sformatf("%s c%0d fwd rd", tag, c), {27'b0, fwd_out.rd}, {27'b0, v.rd});
            check_output($sformatf("%s c%0d fwd opr_res", tag, c), fwd_out.opr_res, v.addr);
            if (mem_ok) begin
                check_output($sformatf("%s c%0d addr", tag, c), dbus.addr, v.addr & 32'hFFFF_FFFC);
                check_output($sformatf("%s c%0d be", tag, c), {28'b0, dbus.be}, {28'b0, v.exp_be});
                check_bit($sformatf("%s c%0d we", tag, c), dbus.we, !is_load);
                if (!is_load) begin
                    check_output($sformatf("%s c%0d wdata", tag, c), dbus.wdata, v.exp_wdata);
                end
            end
            if (lsu_stall) begin
                check_output($sformatf("%s c%0d lsu_rdata", tag, c), wb_out.lsu_rdata, 32'h0);
            end else begin
                done = 1'b1;
                check_bit($sformatf("%s wb rf_en", tag), wb_out.rf_en, v.exp_wb_rf_en);
                check_output($sformatf("%s wb lsu_rdata", tag), wb_out.lsu_rdata, v.exp_rdata);
                check_output($sformatf("%s wb rd", tag), {27'b0, wb_out.rd}, {27'b0, v.rd});
                check_output($sformatf("%s wb opr_res", tag), wb_out.opr_res, v.addr);
                check_output($sformatf("%s wb pc4", tag), wb_out.pc4, pc4);
                check_output($sformatf("%s wb wb_sel", tag), {30'b0, wb_out.wb_sel}, {30'b0, wb_sel});
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s release: stall still high after %0d cycles, expected release after %0d", tag, v.exp_stall + 4, v.exp_stall);
        end
    endtask

    initial begin
        vec_t        v;
        lsuop_t      op;
        logic        dm;
        logic        rf;
        errors = 0;
        checks = 0;

        // Fields: op, dm_en, rf_en, rd, addr, opr_b, rdata, gnt_delay, rv_delay,
        //         exp_be, exp_wdata, exp_rdata, exp_misalign, exp_stall, exp_wb_rf_en
        vectors[0]  = '{SW,  1'b1, 1'b0, 5'd0,  32'h100, 32'hDEADBEEF, 32'h0,         0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,         1'b0, 0, 1'b0};
        vectors[1]  = '{LB,  1'b1, 1'b1, 5'd7,  32'h103, 32'h0,        32'h80FF_FF12, 2, 3, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 6, 1'b1};
        vectors[2]  = '{LHU, 1'b1, 1'b1, 5'd8,  32'h102, 32'h0,        32'h8001_1234, 0, 1, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 2, 1'b1};
        vectors[3]  = '{SH,  1'b1, 1'b0, 5'd0,  32'h102, 32'h0000ABCD, 32'h0,         1, 1, 4'b1100, 32'hABCDABCD, 32'h0,         1'b0, 1, 1'b0};
        vectors[4]  = '{LW,  1'b1, 1'b1, 5'd9,  32'h101, 32'h0,        32'h0,         0, 1, 4'b1111, 32'h0,        32'h0,         1'b1, 0, 1'b0};
        vectors[5]  = '{LB,  1'b0, 1'b1, 5'd5,  32'h42,  32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,         1'b0, 0, 1'b1};
        vectors[6]  = '{LH,  1'b1, 1'b1, 5'd10, 32'h100, 32'h0,        32'h1234_8765, 1, 1, 4'b0011, 32'h0,        32'hFFFF_8765, 1'b0, 3, 1'b1};
        vectors[7]  = '{LBU, 1'b1, 1'b1, 5'd11, 32'h101, 32'h0,        32'h0000_F000, 0, 2, 4'b0010, 32'h0,        32'h0000_00F0, 1'b0, 3, 1'b1};
        vectors[8]  = '{SB,  1'b1, 1'b0, 5'd0,  32'h102, 32'h1234565A, 32'h0,         0, 1, 4'b0100, 32'h5A5A5A5A, 32'h0,         1'b0, 0, 1'b0};
        vectors[9]  = '{LH,  1'b1, 1'b1, 5'd12, 32'h103, 32'h0,        32'h0,         0, 1, 4'b1100, 32'h0,        32'h0,         1'b1, 0, 1'b0};
        vectors[10] = '{LW,  1'b1, 1'b1, 5'd13, 32'h104, 32'h0,        32'hCAFE_F00D, 0, 1, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0, 2, 1'b1};
        vectors[11] = '{LB,  1'b1, 1'b1, 5'd14, 32'h101, 32'h0,        32'h0000_7F00, 3, 1, 4'b0010, 32'h0,        32'h0000_007F, 1'b0, 5, 1'b1};
        vectors[12] = '{SW,  1'b1, 1'b0, 5'd0,  32'h102, 32'h11223344, 32'h0,         0, 1, 4'b1111, 32'h11223344, 32'h0,         1'b1, 0, 1'b0};

        rst         = 1'b1;
        ex_in       = '0;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;
        dbus.rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_bit("reset req", dbus.req, 1'b0);
        check_bit("reset stall", lsu_stall, 1'b0);
        check_bit("reset misalign", lsu_misalign, 1'b0);
        check_bit("reset fwd rf_en", fwd_out.rf_en, 1'b0);
        check_bit("reset wb rf_en", wb_out.rf_en, 1'b0);
        check_output("reset lsu_rdata", wb_out.lsu_rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vectors[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Reset while waiting for load data: the late rvalid must be ignored
        // and the register must come back cleared.
        ex_in.opr_res = 32'h200;
        ex_in.opr_b   = 32'h0;
        ex_in.rd      = 5'd3;
        ex_in.pc4     = 32'h204;
        ex_in.rf_en   = 1'b1;
        ex_in.dm_en   = 1'b1;
        ex_in.wb_sel  = 2'd1;
        ex_in.lsuop   = LW;
        @(posedge clk);
        @(negedge clk);
        dbus.gnt    = 1'b1;
        dbus.rvalid = 1'b0;
        #1;
        check_bit("rstseq req", dbus.req, 1'b1);
        check_bit("rstseq stall gnt", lsu_stall, 1'b1);
        @(negedge clk);
        dbus.gnt = 1'b0;
        #1;
        check_bit("rstseq stall wait", lsu_stall, 1'b1);
        check_bit("rstseq req wait", dbus.req, 1'b0);
        rst           = 1'b1;
        ex_in.opr_res = 32'h77;
        ex_in.rd      = 5'd9;
        ex_in.rf_en   = 1'b1;
        ex_in.dm_en   = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'h1234_5678;
        #1;
        check_bit("rstseq stall after", lsu_stall, 1'b0);
        check_bit("rstseq req after", dbus.req, 1'b0);
        check_bit("rstseq fwd rf_en", fwd_out.rf_en, 1'b0);
        check_output("rstseq fwd opr_res", fwd_out.opr_res, 32'h0);
        check_output("rstseq lsu_rdata", wb_out.lsu_rdata, 32'h0);
        @(negedge clk);
        dbus.rvalid = 1'b0;
        #1;
        check_bit("rstseq late stall", lsu_stall, 1'b0);
        check_output("rstseq late lsu_rdata", wb_out.lsu_rdata, 32'h0);
        check_output("rstseq late fwd opr_res", fwd_out.opr_res, 32'h77);

        for (int i = 0; i < NRND; i++) begin
            op = lsuop_t'($urandom_range(0, 7));
            dm = ($urandom_range(0, 4) != 0);
            if (dm) rf = !((op == SB) || (op == SH) || (op == SW));
            else    rf = 1'($urandom_range(0, 1));
            v = model_vector(op, dm, rf, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                             $urandom_range(0, 3), $urandom_range(1, 3));
            apply_stimulus(v, $sformatf("rnd%0d", i), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
